// File: rtl/e203_ifu_thrd_sched_pkg.sv
// -----------------------------------------------------------------------------
// e203_ifu_thrd_sched_pkg
// Shared definitions for the IFU hardware-thread scheduler and the IO-side
// arbiter: thread count, thread-ID width, default fetch quantum and the
// per-thread state encoding.
// -----------------------------------------------------------------------------
package e203_ifu_thrd_sched_pkg;

  localparam int E203_THRD_NUM     = 4;
  localparam int E203_THRD_TID_W   = 2;
  localparam int E203_THRD_QUANTUM = 4;

  // Quantum counter width; covers the largest supported quantum of 16.
  localparam int E203_THRD_QCNT_W  = 4;

  typedef enum logic [1:0] {
    THRD_IDLE     = 2'd0,
    THRD_RUN      = 2'd1,
    THRD_PARK_IN  = 2'd2,
    THRD_PARK_OUT = 2'd3
  } thrd_state_e;

  // True for either of the two waiting states.
  function automatic logic thrd_is_parked(input thrd_state_e s);
    return (s == THRD_PARK_IN) || (s == THRD_PARK_OUT);
  endfunction

endpackage

// File: rtl/e203_ifu_thrd_rrpick.sv
// -----------------------------------------------------------------------------
// e203_ifu_thrd_rrpick
// Combinational round-robin finder: returns the first set bit of run_mask
// at or after index start, wrapping modulo THREADS.
//
// Ports:
//   run_mask  in   THREADS  candidate threads
//   start     in   TID_W    first index to examine
//   found     out  1        some bit of run_mask is set
//   tid       out  TID_W    index of the chosen thread (0 when !found)
// -----------------------------------------------------------------------------
module e203_ifu_thrd_rrpick
  import e203_ifu_thrd_sched_pkg::*;
#(
  parameter int THREADS = E203_THRD_NUM,
  parameter int TID_W   = E203_THRD_TID_W
) (
  input  logic [THREADS-1:0] run_mask,
  input  logic [TID_W-1:0]   start,
  output logic               found,
  output logic [TID_W-1:0]   tid
);

  logic [TID_W-1:0] idx_s;

  // Scan from the farthest candidate back to start so the nearest hit wins;
  // THREADS is a power of two, so the TID_W-bit add wraps naturally.
  always_comb begin
    found = 1'b0;
    tid   = {TID_W{1'b0}};
    idx_s = start;
    for (int k = THREADS - 1; k >= 0; k--) begin
      idx_s = start + TID_W'(k);
      found = run_mask[idx_s] ? 1'b1 : found;
      tid   = run_mask[idx_s] ? idx_s : tid;
    end
  end

endmodule

// File: rtl/e203_ifu_thrd_sched.sv
// -----------------------------------------------------------------------------
// e203_ifu_thrd_sched
// Fetch-side hardware-thread scheduler. Each thread runs a small FSM
// (IDLE/RUN/PARK_IN/PARK_OUT); the scheduler presents one RUN thread to the
// IFU, rotating round-robin after QUANTUM accepted fetches, and skips any
// current thread that has left RUN with a single bubble cycle.
//
// Ports:
//   clk, rst          core clock, synchronous active-high reset
//   thr_enable        per-thread enable from CSR
//   sched_valid/ready fetch handshake for sched_tid
//   sched_tid         thread ID to fetch
//   dec_*             mini-decode result (TTIAT/TTOAT park requests)
//   io_in_done        per-thread input-completion pulse (wakes PARK_IN)
//   io_out_done       per-thread output-completion pulse (wakes PARK_OUT)
//   thr_run           thread in RUN
//   thr_parked        thread in PARK_IN or PARK_OUT
//   all_parked        some thread active and none in RUN
// -----------------------------------------------------------------------------
module e203_ifu_thrd_sched
  import e203_ifu_thrd_sched_pkg::*;
#(
  parameter int THREADS = E203_THRD_NUM,
  parameter int TID_W   = E203_THRD_TID_W,
  parameter int QUANTUM = E203_THRD_QUANTUM
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [THREADS-1:0] thr_enable,
  output logic               sched_valid,
  input  logic               sched_ready,
  output logic [TID_W-1:0]   sched_tid,
  input  logic               dec_valid,
  input  logic [TID_W-1:0]   dec_tid,
  input  logic               dec_ttiat,
  input  logic               dec_ttoat,
  input  logic [THREADS-1:0] io_in_done,
  input  logic [THREADS-1:0] io_out_done,
  output logic [THREADS-1:0] thr_run,
  output logic [THREADS-1:0] thr_parked,
  output logic               all_parked
);

  localparam int QCNT_W = E203_THRD_QCNT_W;

  logic [THREADS-1:0] run_s;
  logic [THREADS-1:0] nxt_run_s;
  logic [THREADS-1:0] nxt_park_s;

  logic [TID_W-1:0]   cur_tid_r;
  logic [TID_W-1:0]   nxt_cur_tid_s;
  logic [QCNT_W-1:0]  qcnt_r;
  logic [QCNT_W-1:0]  nxt_qcnt_s;

  logic               sched_valid_r;
  logic [THREADS-1:0] thr_run_r;
  logic [THREADS-1:0] thr_parked_r;
  logic               all_parked_r;

  logic               cur_run_s;
  logic               accept_s;
  logic               pick_found_s;
  logic [TID_W-1:0]   pick_tid_s;

  // ---------------------------------------------------------------------------
  // Per-thread state machines
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < THREADS; i++) begin : g_thrd
    thrd_state_e state_r;
    thrd_state_e nxt_state_s;
    logic        dec_hit_s;

    // Decodes only matter for a thread currently in RUN (checked in the FSM).
    assign dec_hit_s = dec_valid & (dec_tid == TID_W'(i));

    // Next-state logic: disable wins; a park that meets its own completion
    // in the same cycle is consumed and the thread stays in RUN.
    always_comb begin
      nxt_state_s = state_r;
      if (!thr_enable[i]) begin
        nxt_state_s = THRD_IDLE;
      end else begin
        case (state_r)
          THRD_IDLE: nxt_state_s = THRD_RUN;
          THRD_RUN: begin
            if (dec_hit_s & dec_ttiat) begin
              nxt_state_s = io_in_done[i] ? THRD_RUN : THRD_PARK_IN;
            end else if (dec_hit_s & dec_ttoat) begin
              nxt_state_s = io_out_done[i] ? THRD_RUN : THRD_PARK_OUT;
            end else begin
              nxt_state_s = THRD_RUN;
            end
          end
          THRD_PARK_IN:  nxt_state_s = io_in_done[i]  ? THRD_RUN : THRD_PARK_IN;
          THRD_PARK_OUT: nxt_state_s = io_out_done[i] ? THRD_RUN : THRD_PARK_OUT;
          default:       nxt_state_s = THRD_IDLE;
        endcase
      end
    end

    // Thread state register.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_r <= THRD_IDLE;
      end else begin
        state_r <= nxt_state_s;
      end
    end

    assign run_s[i]      = (state_r == THRD_RUN);
    assign nxt_run_s[i]  = (nxt_state_s == THRD_RUN);
    assign nxt_park_s[i] = thrd_is_parked(nxt_state_s);
  end

  // ---------------------------------------------------------------------------
  // Scheduler
  // ---------------------------------------------------------------------------
  assign cur_run_s = run_s[cur_tid_r];
  assign accept_s  = cur_run_s & sched_ready;

  // Search starts just past the current thread; the current thread itself is
  // the last candidate, so "no other RUN thread" naturally keeps cur_tid.
  e203_ifu_thrd_rrpick #(
    .THREADS (THREADS),
    .TID_W   (TID_W)
  ) u_rrpick (
    .run_mask (run_s),
    .start    (cur_tid_r + TID_W'(1)),
    .found    (pick_found_s),
    .tid      (pick_tid_s)
  );

  // Current-thread and quantum update: bubble skip, quantum rotation or hold.
  always_comb begin
    nxt_cur_tid_s = cur_tid_r;
    nxt_qcnt_s    = qcnt_r;
    if (!cur_run_s) begin
      nxt_qcnt_s    = {QCNT_W{1'b0}};
      nxt_cur_tid_s = pick_found_s ? pick_tid_s : cur_tid_r;
    end else if (accept_s) begin
      if (qcnt_r == QCNT_W'(QUANTUM - 1)) begin
        nxt_qcnt_s    = {QCNT_W{1'b0}};
        nxt_cur_tid_s = pick_found_s ? pick_tid_s : cur_tid_r;
      end else begin
        nxt_qcnt_s    = qcnt_r + QCNT_W'(1);
        nxt_cur_tid_s = cur_tid_r;
      end
    end else begin
      nxt_qcnt_s    = qcnt_r;
      nxt_cur_tid_s = cur_tid_r;
    end
  end

  // Scheduler registers; status outputs are registered from next-state values
  // so they line up exactly with the thread state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_tid_r     <= {TID_W{1'b0}};
      qcnt_r        <= {QCNT_W{1'b0}};
      sched_valid_r <= 1'b0;
      thr_run_r     <= {THREADS{1'b0}};
      thr_parked_r  <= {THREADS{1'b0}};
      all_parked_r  <= 1'b0;
    end else begin
      cur_tid_r     <= nxt_cur_tid_s;
      qcnt_r        <= nxt_qcnt_s;
      sched_valid_r <= nxt_run_s[nxt_cur_tid_s];
      thr_run_r     <= nxt_run_s;
      thr_parked_r  <= nxt_park_s;
      all_parked_r  <= (|nxt_park_s) & ~(|nxt_run_s);
    end
  end

  assign sched_valid = sched_valid_r;
  assign sched_tid   = cur_tid_r;
  assign thr_run     = thr_run_r;
  assign thr_parked  = thr_parked_r;
  assign all_parked  = all_parked_r;

endmodule

// File: tb/tb_e203_ifu_thrd_sched.sv
module tb_e203_ifu_thrd_sched;

  localparam int THREADS = 4;
  localparam int TID_W   = 2;
  localparam int QUANTUM = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [THREADS-1:0] thr_enable;
  logic               sched_valid;
  logic               sched_ready;
  logic [TID_W-1:0]   sched_tid;
  logic               dec_valid;
  logic [TID_W-1:0]   dec_tid;
  logic               dec_ttiat;
  logic               dec_ttoat;
  logic [THREADS-1:0] io_in_done;
  logic [THREADS-1:0] io_out_done;
  logic [THREADS-1:0] thr_run;
  logic [THREADS-1:0] thr_parked;
  logic               all_parked;

  always #5 clk = ~clk;

  e203_ifu_thrd_sched #(
    .THREADS (THREADS),
    .TID_W   (TID_W),
    .QUANTUM (QUANTUM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .thr_enable  (thr_enable),
    .sched_valid (sched_valid),
    .sched_ready (sched_ready),
    .sched_tid   (sched_tid),
    .dec_valid   (dec_valid),
    .dec_tid     (dec_tid),
    .dec_ttiat   (dec_ttiat),
    .dec_ttoat   (dec_ttoat),
    .io_in_done  (io_in_done),
    .io_out_done (io_out_done),
    .thr_run     (thr_run),
    .thr_parked  (thr_parked),
    .all_parked  (all_parked)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [3:0] en;
    logic       rdy;
    logic       dv;
    logic [1:0] dtid;
    logic       ti;
    logic       to;
    logic [3:0] iin;
    logic [3:0] iout;
    logic       ev;
    logic [1:0] etid;
    logic [3:0] erun;
    logic [3:0] epark;
    logic       eap;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(input string name, input logic r, input logic [3:0] en,
                              input logic rdy, input logic dv, input logic [1:0] dtid,
                              input logic ti, input logic to, input logic [3:0] iin,
                              input logic [3:0] iout, input logic ev, input logic [1:0] etid,
                              input logic [3:0] erun, input logic [3:0] epark, input logic eap);
    vec_t v;
    v.name = name; v.rst = r; v.en = en; v.rdy = rdy; v.dv = dv; v.dtid = dtid;
    v.ti = ti; v.to = to; v.iin = iin; v.iout = iout;
    v.ev = ev; v.etid = etid; v.erun = erun; v.epark = epark; v.eap = eap;
    return v;
  endfunction

  // Drive one cycle of inputs, let one edge pass, then compare all outputs.
  task automatic run_vec(input vec_t v);
    logic [11:0] got;
    logic [11:0] exp;
    @(negedge clk);
    rst         = v.rst;
    thr_enable  = v.en;
    sched_ready = v.rdy;
    dec_valid   = v.dv;
    dec_tid     = v.dtid;
    dec_ttiat   = v.ti;
    dec_ttoat   = v.to;
    io_in_done  = v.iin;
    io_out_done = v.iout;
    @(posedge clk);
    #1;
    got = {sched_valid, sched_tid, thr_run, thr_parked, all_parked};
    exp = {v.ev, v.etid, v.erun, v.epark, v.eap};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got v=%0b tid=%0d run=%b park=%b ap=%0b, expected v=%0b tid=%0d run=%b park=%b ap=%0b",
               v.name, sched_valid, sched_tid, thr_run, thr_parked, all_parked,
               v.ev, v.etid, v.erun, v.epark, v.eap);
    end
  endtask

  initial begin
    rst = 1'b1; thr_enable = 4'b0000; sched_ready = 1'b0; dec_valid = 1'b0;
    dec_tid = 2'd0; dec_ttiat = 1'b0; dec_ttoat = 1'b0;
    io_in_done = 4'b0000; io_out_done = 4'b0000;

    // Main table: enable all, quantum rotation, park/wake, ready hold, disable.
    //                name          rst  en       rdy   dv    dtid  ti    to    iin      iout     ev    tid   run      park     ap
    tbl.push_back(mk("reset",       1'b1, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk("idle",        1'b0, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0));
    tbl.push_back(mk("enable",      1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("quantum0",  1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0));
    tbl.push_back(mk("rotate1",     1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0));
    tbl.push_back(mk("park1_in",    1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd1, 4'b1101, 4'b0010, 1'b0));
    tbl.push_back(mk("bubble_to2",  1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'b1101, 4'b0010, 1'b0));
    tbl.push_back(mk("wake1",       1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0010, 4'b0000, 1'b1, 2'd2, 4'b1111, 4'b0000, 1'b0));
    tbl.push_back(mk("park2_done",  1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 4'b0000, 4'b0100, 1'b1, 2'd2, 4'b1111, 4'b0000, 1'b0));
    tbl.push_back(mk("quantum2",    1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd2, 4'b1111, 4'b0000, 1'b0));
    tbl.push_back(mk("rotate3",     1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b1111, 4'b0000, 1'b0));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk("hold3",     1'b0, 4'b1111, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b1111, 4'b0000, 1'b0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk("quantum3",  1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd3, 4'b1111, 4'b0000, 1'b0));
    tbl.push_back(mk("wrap0",       1'b0, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b1111, 4'b0000, 1'b0));
    tbl.push_back(mk("disable0",    1'b0, 4'b1110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b1110, 4'b0000, 1'b0));
    tbl.push_back(mk("bubble_to1",  1'b0, 4'b1110, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1, 4'b1110, 4'b0000, 1'b0));
    tbl.push_back(mk("stale_dec0",  1'b0, 4'b1110, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd1, 4'b1110, 4'b0000, 1'b0));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

    // Single thread: park on TTIAT, wrong completion ignored, right one wakes.
    run_vec(mk("s_reset",       1'b1, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0));
    run_vec(mk("s_enable0",     1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0));
    run_vec(mk("s_park0",       1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1));
    run_vec(mk("s_wrong_done",  1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1));
    run_vec(mk("s_wake0",       1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0001, 4'b0000, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0));

    // Only one RUN thread: quantum expiry keeps the same tid.
    for (int i = 0; i < 5; i++)
      run_vec(mk("s_solo_quant", 1'b0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0));

    // Both flags: TTIAT wins, so an output completion must not wake it.
    run_vec(mk("s_both_flags",  1'b0, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1));
    run_vec(mk("s_out_ignored", 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b0, 2'd0, 4'b0000, 4'b0001, 1'b1));

    // Reset while parked drops the wait; thread restarts from IDLE.
    run_vec(mk("s_rst_parked",  1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0));
    run_vec(mk("s_rerun",       1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 2'd0, 4'b0001, 4'b0000, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
